// File: rtl/serial_bus_master.sv
// Serial bus master: arbitrates for a shared one-wire bus, then shifts out start bit, slave ID,
// address and (for writes) data MSB first, or waits for and shifts in a slave read response.
module serial_bus_master #(
  parameter int unsigned ADDRESS_WIDTH  = 15,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned SLAVE_ID_WIDTH = 3,
  parameter int unsigned TIMEOUT        = 255
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic                      wr_in,
  input  logic [SLAVE_ID_WIDTH-1:0] slave_id_in,
  input  logic [ADDRESS_WIDTH-1:0]  addr_in,
  input  logic [DATA_WIDTH-1:0]     wdata_in,
  output logic                      arb_req,
  input  logic                      arbiter_cmd_in,
  output logic                      bus_util,
  output logic                      rd_wrt,
  inout  wire                       data_bus_serial,
  output logic [DATA_WIDTH-1:0]     rdata_out,
  output logic                      done,
  output logic                      err,
  output logic                      busy,
  output logic [3:0]                state_out
);

  localparam int unsigned MaxAd  = (ADDRESS_WIDTH > DATA_WIDTH) ? ADDRESS_WIDTH : DATA_WIDTH;
  localparam int unsigned MaxCnt = (MaxAd > TIMEOUT) ? MaxAd : TIMEOUT;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);
  localparam int unsigned TxW    = (MaxAd > SLAVE_ID_WIDTH) ? MaxAd : SLAVE_ID_WIDTH;

  localparam logic [CntW-1:0] SidLast  = CntW'(SLAVE_ID_WIDTH - 1);
  localparam logic [CntW-1:0] AddrLast = CntW'(ADDRESS_WIDTH - 1);
  localparam logic [CntW-1:0] DataLast = CntW'(DATA_WIDTH - 1);
  localparam logic [CntW-1:0] ToLast   = CntW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StReq    = 4'd1,
    StStart  = 4'd2,
    StSid    = 4'd3,
    StAddr   = 4'd4,
    StWdata  = 4'd5,
    StRdWait = 4'd6,
    StRdata  = 4'd7,
    StDone   = 4'd8,
    StErr    = 4'd9
  } state_e;

  state_e                    state_q, state_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [TxW-1:0]            tx_q, tx_d;
  logic [DATA_WIDTH-1:0]     shift_q, shift_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic                      wr_q;
  logic [SLAVE_ID_WIDTH-1:0] sid_q;
  logic [ADDRESS_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic                      drive_en, drive_bit;
  logic                      line_zero;

  // Only a clean 0 counts as the slave start bit; X/Z fall through to the else branch.
  assign line_zero = (data_bus_serial == 1'b0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      tx_q    <= '0;
      shift_q <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      sid_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      shift_q <= shift_d;
      rdata_q <= rdata_d;
      if (state_q == StIdle && start) begin
        wr_q    <= wr_in;
        sid_q   <= slave_id_in;
        addr_q  <= addr_in;
        wdata_q <= wdata_in;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StReq;
      StReq:    if (arbiter_cmd_in) state_d = StStart;
      StStart:  state_d = StSid;
      StSid:    if (cnt_q == SidLast) state_d = StAddr;
      StAddr:   if (cnt_q == AddrLast) state_d = wr_q ? StWdata : StRdWait;
      StWdata:  if (cnt_q == DataLast) state_d = StDone;
      StRdWait: begin
        if (line_zero) state_d = StRdata;
        else if (cnt_q == ToLast) state_d = StErr;
      end
      StRdata:  if (cnt_q == DataLast) state_d = StDone;
      StDone:   state_d = StIdle;
      StErr:    state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Datapath next-state: counter, transmit shifter (reloaded per field), receive shifter.
  always_comb begin
    cnt_d   = (state_d != state_q) ? '0 : cnt_q + 1'b1;
    tx_d    = tx_q << 1;
    shift_d = shift_q;
    rdata_d = rdata_q;
    if (state_d != state_q) begin
      case (state_d)
        StSid:   tx_d = TxW'(sid_q) << (TxW - SLAVE_ID_WIDTH);
        StAddr:  tx_d = TxW'(addr_q) << (TxW - ADDRESS_WIDTH);
        StWdata: tx_d = TxW'(wdata_q) << (TxW - DATA_WIDTH);
        default: tx_d = tx_q;
      endcase
    end
    if (state_q == StRdata) begin
      shift_d = {shift_q[DATA_WIDTH-2:0], data_bus_serial};
      if (state_d == StDone) rdata_d = {shift_q[DATA_WIDTH-2:0], data_bus_serial};
    end
  end

  always_comb begin
    arb_req   = (state_q == StReq);
    bus_util  = 1'b1;
    drive_en  = 1'b0;
    drive_bit = 1'b0;
    unique case (state_q)
      StStart: begin
        bus_util = 1'b0;
        drive_en = 1'b1;
      end
      StSid, StAddr, StWdata: begin
        bus_util  = 1'b0;
        drive_en  = 1'b1;
        drive_bit = tx_q[TxW-1];
      end
      StRdWait, StRdata, StDone, StErr: bus_util = 1'b0;
      default: bus_util = 1'b1;
    endcase
    rd_wrt    = bus_util ? 1'b0 : wr_q;
    done      = (state_q == StDone);
    err       = (state_q == StErr);
    busy      = (state_q != StIdle);
    state_out = state_q;
  end

  assign data_bus_serial = drive_en ? drive_bit : 1'bz;
  assign rdata_out       = rdata_q;

endmodule

// File: tb/tb_serial_bus_master.sv
// Scoreboard bench for serial_bus_master: stimulus queues expected completions and signal probes,
// a negedge monitor captures the serial frame and checks everything against those queues.
module tb_serial_bus_master;

  logic        clk;
  logic        rstn;
  logic        start;
  logic        wr_in;
  logic [2:0]  slave_id_in;
  logic [14:0] addr_in;
  logic [7:0]  wdata_in;
  logic        arb_req;
  logic        arbiter_cmd_in;
  logic        bus_util;
  logic        rd_wrt;
  wire         data_bus_serial;
  logic [7:0]  rdata_out;
  logic        done;
  logic        err;
  logic        busy;
  logic [3:0]  state_out;
  logic        slv_en;
  logic        slv_bit;

  serial_bus_master dut (
    .clk            (clk),
    .rstn           (rstn),
    .start          (start),
    .wr_in          (wr_in),
    .slave_id_in    (slave_id_in),
    .addr_in        (addr_in),
    .wdata_in       (wdata_in),
    .arb_req        (arb_req),
    .arbiter_cmd_in (arbiter_cmd_in),
    .bus_util       (bus_util),
    .rd_wrt         (rd_wrt),
    .data_bus_serial(data_bus_serial),
    .rdata_out      (rdata_out),
    .done           (done),
    .err            (err),
    .busy           (busy),
    .state_out      (state_out)
  );

  // Released line idles high so it can never be mistaken for a start bit.
  assign data_bus_serial = slv_en ? slv_bit : 1'bz;
  pullup (data_bus_serial);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    logic [7:0]  rdata;
    int          nbits;
    logic [26:0] frame;
    int          cyc;
  } exp_t;

  typedef enum {PrArbReq, PrBusUtil, PrRdWrt, PrLine, PrBusy, PrState, PrRdata, PrDone, PrErr,
                PrSbEmpty} probe_e;

  typedef struct {
    probe_e      kind;
    logic [31:0] exp;
    string       name;
  } probe_t;

  exp_t   sb[$];
  probe_t pq[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  logic [7:0] last_rd = 8'h00;

  function automatic logic [31:0] probe_val(probe_e k);
    case (k)
      PrArbReq:  return {31'b0, arb_req};
      PrBusUtil: return {31'b0, bus_util};
      PrRdWrt:   return {31'b0, rd_wrt};
      PrLine:    return {31'b0, data_bus_serial};
      PrBusy:    return {31'b0, busy};
      PrState:   return {28'b0, state_out};
      PrRdata:   return {24'b0, rdata_out};
      PrDone:    return {31'b0, done};
      PrErr:     return {31'b0, err};
      default:   return sb.size();
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: evaluates queued probes and scores every done/err pulse.
  initial begin : monitor
    logic [26:0] cap;
    int          cap_n;
    probe_t      p;
    exp_t        e;
    cap   = '0;
    cap_n = 0;
    forever begin
      @(negedge clk);
      while (pq.size() > 0) begin
        p = pq.pop_front();
        check(p.name, probe_val(p.kind), p.exp);
      end
      if (done || err) begin
        if (sb.size() == 0) begin
          check("unexpected_completion", {30'b0, done, err}, 32'h0);
        end else begin
          e = sb.pop_front();
          check("completion_kind", {30'b0, done, err}, e.is_err ? 32'h1 : 32'h2);
          check("rdata_out", {24'b0, rdata_out}, {24'b0, e.rdata});
          check("frame_bits", 32'(cap >> (27 - e.nbits)), 32'(e.frame));
          check("completion_cycle", 32'(cyc), 32'(e.cyc));
        end
        cap   = '0;
        cap_n = 0;
      end else if (!bus_util && cap_n < 27) begin
        cap[26-cap_n] = data_bus_serial;
        cap_n++;
      end
      if (!rstn) begin
        cap   = '0;
        cap_n = 0;
      end
    end
  end

  task automatic probe(input probe_e k, input logic [31:0] e, input string nm);
    pq.push_back('{kind: k, exp: e, name: nm});
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_probes(input string tag);
    probe(PrBusy, 32'h0, {tag, "_busy"});
    probe(PrBusUtil, 32'h1, {tag, "_bus_util"});
    probe(PrState, 32'h0, {tag, "_state"});
    probe(PrRdWrt, 32'h0, {tag, "_rd_wrt"});
    probe(PrArbReq, 32'h0, {tag, "_arb_req"});
    probe(PrLine, 32'h1, {tag, "_line"});
  endtask

  // k: REQ cycles including the one where grant is sampled; w: RD_WAIT cycles up to the
  // slave start bit (0 = slave never answers); inj: pulse a stray start during ADDR.
  task automatic do_txn(input bit wr, input logic [2:0] id, input logic [14:0] addr,
                        input logic [7:0] wd, input int k, input int w, input logic [7:0] rd,
                        input bit inj);
    exp_t e;
    int   s;
    bit   injected;
    step();
    start = 1'b1;
    wr_in = wr;
    slave_id_in = id;
    addr_in = addr;
    wdata_in = wd;
    s = cyc + 1;
    if (wr) begin
      e = '{is_err: 1'b0, rdata: last_rd, nbits: 27, frame: {1'b0, id, addr, wd},
            cyc: s + k + 27};
    end else if (w > 0) begin
      e = '{is_err: 1'b0, rdata: rd, nbits: 19, frame: {8'b0, 1'b0, id, addr},
            cyc: s + k + 19 + w + 8};
      last_rd = rd;
    end else begin
      e = '{is_err: 1'b1, rdata: last_rd, nbits: 19, frame: {8'b0, 1'b0, id, addr},
            cyc: s + k + 19 + 255};
    end
    sb.push_back(e);
    step();
    start = 1'b0;
    wr_in = 1'b0;
    slave_id_in = '0;
    addr_in = '0;
    wdata_in = '0;
    for (int i = 1; i < k; i++) begin
      probe(PrArbReq, 32'h1, "req_arb_req");
      probe(PrBusUtil, 32'h1, "req_bus_util");
      probe(PrLine, 32'h1, "req_line_released");
      step();
    end
    arbiter_cmd_in = 1'b1;
    step();
    arbiter_cmd_in = 1'b0;
    probe(PrArbReq, 32'h0, "start_arb_req");
    probe(PrBusUtil, 32'h0, "start_bus_util");
    probe(PrRdWrt, {31'b0, wr}, "start_rd_wrt");
    injected = 1'b0;
    for (int t = 0; t < 400 && sb.size() > 0; t++) begin
      if (inj && !injected && state_out == 4'd4) begin
        start = 1'b1;
        wr_in = ~wr;
        slave_id_in = 3'h7;
        addr_in = 15'h7fff;
        wdata_in = 8'hff;
        injected = 1'b1;
        step();
        start = 1'b0;
      end else if (!wr && w > 0 && state_out == 4'd6) begin
        repeat (w - 1) step();
        slv_en = 1'b1;
        slv_bit = 1'b0;
        for (int b = 7; b >= 0; b--) begin
          step();
          slv_bit = rd[b];
        end
        step();
        slv_en = 1'b0;
      end else begin
        step();
      end
    end
    probe(PrSbEmpty, 32'h0, "txn_completed");
    step();
    idle_probes("post_txn");
    probe(PrDone, 32'h0, "done_single_pulse");
    probe(PrErr, 32'h0, "err_single_pulse");
    step();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    rstn = 1'b0;
    start = 1'b0;
    wr_in = 1'b0;
    slave_id_in = '0;
    addr_in = '0;
    wdata_in = '0;
    arbiter_cmd_in = 1'b0;
    slv_en = 1'b0;
    slv_bit = 1'b0;
    #1;
    idle_probes("reset");
    probe(PrRdata, 32'h0, "reset_rdata");
    probe(PrDone, 32'h0, "reset_done");
    probe(PrErr, 32'h0, "reset_err");
    step();
    step();
    rstn = 1'b1;
    step();

    // Write id=3 addr=5 data=A5, grant in the second REQ cycle.
    do_txn(1'b1, 3'd3, 15'h0005, 8'ha5, 2, 0, 8'h00, 1'b0);
    // Read id=0 addr=0x10, slave start bit in the 4th RD_WAIT cycle, data 0x3C.
    do_txn(1'b0, 3'd0, 15'h0010, 8'h00, 1, 4, 8'h3c, 1'b0);
    // Read with no answer: timeout after 255 RD_WAIT cycles, rdata held at 0x3C.
    do_txn(1'b0, 3'd2, 15'h0123, 8'h00, 1, 0, 8'h00, 1'b0);
    probe(PrRdata, 32'h3c, "rdata_held_after_err");
    // Stray start during ADDR must not disturb the frame or spawn a second transaction.
    do_txn(1'b1, 3'd5, 15'h1234, 8'h3c, 1, 0, 8'h00, 1'b1);
    repeat (3) begin
      idle_probes("no_second_txn");
      step();
    end
    // Grant withheld for 100 REQ cycles.
    do_txn(1'b1, 3'd1, 15'h7fff, 8'h81, 101, 0, 8'h00, 1'b0);

    // Reset in ADDR of a write: bus released at once, no completion, nothing resumes.
    step();
    start = 1'b1;
    wr_in = 1'b1;
    slave_id_in = 3'd4;
    addr_in = 15'h4321;
    wdata_in = 8'h77;
    step();
    start = 1'b0;
    arbiter_cmd_in = 1'b1;
    step();
    arbiter_cmd_in = 1'b0;
    for (int t = 0; t < 20 && state_out != 4'd4; t++) step();
    probe(PrState, 32'h4, "reached_addr");
    step();
    rstn = 1'b0;
    #1;
    idle_probes("mid_reset");
    probe(PrRdata, 32'h0, "mid_reset_rdata");
    step();
    rstn = 1'b1;
    last_rd = 8'h00;
    repeat (5) begin
      idle_probes("after_reset");
      probe(PrDone, 32'h0, "after_reset_done");
      step();
    end
    do_txn(1'b1, 3'd6, 15'h2aaa, 8'h5a, 1, 0, 8'h00, 1'b0);

    probe(PrSbEmpty, 32'h0, "scoreboard_drained");
    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
